// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, exponent bias, the +inf bit pattern,
// and the state encoding of the fixed-point to fp16 converter.
package fp16_pkg;

    localparam int unsigned EXP_W    = 5;
    localparam int unsigned MANT_W   = 10;
    localparam int unsigned EXP_BIAS = 15;

    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND
    } state_e;

endpackage

// File: rtl/fp16_pack_round.sv
// Combinational fp16 rounding and packing stage.
// Ports:
//   m          normalised magnitude (MSB is the hidden one), or all zeros for a zero value
//   sign       sign of the result
//   exp_biased signed, biased exponent before rounding
//   fp         packed binary16 word
//   ovf        result saturated to +/-inf
//   uf         nonzero result flushed to +/-0 (no subnormals are produced)
module fp16_pack_round
    import fp16_pkg::*;
#(
    parameter int unsigned M_WIDTH = 32,
    parameter int unsigned E_WIDTH = 9
) (
    input  logic [M_WIDTH-1:0]        m,
    input  logic                      sign,
    input  logic signed [E_WIDTH-1:0] exp_biased,
    output logic [15:0]               fp,
    output logic                      ovf,
    output logic                      uf
);

    localparam logic signed [E_WIDTH-1:0] EXP_MAX  = E_WIDTH'(2**EXP_W - 1);
    localparam logic signed [E_WIDTH-1:0] EXP_ZERO = '0;

    logic [MANT_W-1:0]         mant;
    logic                      guard;
    logic                      sticky;
    logic                      round_up;
    logic [MANT_W:0]           mant_sum;
    logic signed [E_WIDTH-1:0] carry_ext;
    logic signed [E_WIDTH-1:0] exp_adj;

    assign mant     = m[M_WIDTH-2 -: MANT_W];
    assign guard    = m[M_WIDTH-2-MANT_W];
    assign sticky   = |m[M_WIDTH-3-MANT_W:0];
    // Round to nearest, ties to even.
    assign round_up = guard & (sticky | mant[0]);
    assign mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};

    always_comb begin
        // A mantissa carry-out leaves the stored fraction at zero and bumps the exponent.
        carry_ext    = '0;
        carry_ext[0] = mant_sum[MANT_W];
        exp_adj      = exp_biased + carry_ext;
        fp           = '0;
        ovf          = 1'b0;
        uf           = 1'b0;
        if (m == '0) begin
            fp = '0;
        end else if (exp_adj >= EXP_MAX) begin
            fp  = {sign, POS_INF[14:0]};
            ovf = 1'b1;
        end else if (exp_adj <= EXP_ZERO) begin
            fp = {sign, 15'b0};
            uf = 1'b1;
        end else begin
            fp = {sign, exp_adj[EXP_W-1:0], mant_sum[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fixed_to_fp16.sv
// Converts a signed fixed-point accumulator value with a shared fp16-biased
// exponent into an IEEE-754 binary16 word. Normalisation shifts one bit per cycle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           one-cycle request, sampled only while idle
//   exp_in          shared exponent, bias 15
//   fixed_point_in  two's-complement accumulator value
//   fp_out          packed fp16 result, held until the next done
//   busy            conversion in progress
//   done            one-cycle pulse, fp_out/ovf/uf valid from this cycle
//   ovf, uf         saturated to inf / flushed to zero, held with fp_out
module fixed_to_fp16
    import fp16_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned FRAC_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W-1:0]     exp_in,
    input  logic [ACC_WIDTH-1:0] fixed_point_in,
    output logic [15:0]          fp_out,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 uf
);

    localparam int unsigned K_W = $clog2(ACC_WIDTH);
    localparam int unsigned E_W = K_W + 4;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] m_q, m_d;
    logic                 sign_q, sign_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic [K_W-1:0]       k_q, k_d;
    logic                 zero_q, zero_d;
    logic [15:0]          fp_q, fp_d;
    logic                 ovf_q, ovf_d;
    logic                 uf_q, uf_d;
    logic                 done_q, done_d;

    logic signed [E_W-1:0] e_round;
    logic [15:0]           pack_fp;
    logic                  pack_ovf;
    logic                  pack_uf;

    // Biased exponent of the normalised value: the leading one sits at bit
    // ACC_WIDTH-1, i.e. ACC_WIDTH-1-FRAC_BITS above the binary point, less k shifts.
    assign e_round = $signed(E_W'(ACC_WIDTH - 1 - FRAC_BITS))
                   + $signed({{(E_W-EXP_W){1'b0}}, exp_q})
                   - $signed({{(E_W-K_W){1'b0}}, k_q});

    fp16_pack_round #(
        .M_WIDTH (ACC_WIDTH),
        .E_WIDTH (E_W)
    ) u_pack (
        .m          (m_q),
        .sign       (sign_q),
        .exp_biased (e_round),
        .fp         (pack_fp),
        .ovf        (pack_ovf),
        .uf         (pack_uf)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        k_d     = k_q;
        zero_d  = zero_q;
        fp_d    = fp_q;
        ovf_d   = ovf_q;
        uf_d    = uf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = fixed_point_in[ACC_WIDTH-1];
                    // Negating the most negative value wraps to 2^(ACC_WIDTH-1), which is
                    // the correct unsigned magnitude.
                    m_d     = fixed_point_in[ACC_WIDTH-1] ? ('0 - fixed_point_in)
                                                          : fixed_point_in;
                    exp_d   = exp_in;
                    k_d     = '0;
                    zero_d  = (fixed_point_in == '0);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (m_q[ACC_WIDTH-1] || zero_q) begin
                    state_d = ROUND;
                end else begin
                    m_d = m_q << 1;
                    k_d = k_q + K_W'(1);
                end
            end
            ROUND: begin
                fp_d    = pack_fp;
                ovf_d   = pack_ovf;
                uf_d    = pack_uf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            fp_q    <= '0;
            ovf_q   <= 1'b0;
            uf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            fp_q    <= fp_d;
            ovf_q   <= ovf_d;
            uf_q    <= uf_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign fp_out = fp_q;
    assign ovf    = ovf_q;
    assign uf     = uf_q;

endmodule
